// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file write types and the B-side buffer entry used by the write arbiter.
package regfile_write_arbiter_pkg;

    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned WordWidth    = 32;
    localparam int unsigned NumRegs      = 1 << RegAddrWidth;

    typedef logic [RegAddrWidth-1:0] RegAddress;
    typedef logic [WordWidth-1:0]    Word;

    typedef struct packed {
        RegAddress addr;
        Word       data;
    } BufEntry;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of pipeline (A), long-latency (B) and register-file write-port signals.
// Build option: REGFILE_SCOREBOARD_EN adds claim_valid/claim_addr/busy.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic      a_valid;
    RegAddress a_addr;
    Word       a_data;
    logic      a_ready;
    logic      b_valid;
    logic      b_ready;
    RegAddress b_addr;
    Word       b_data;
    logic      rf_write_enable;
    RegAddress rf_addr_write;
    Word       rf_in;
`ifdef REGFILE_SCOREBOARD_EN
    logic               claim_valid;
    RegAddress          claim_addr;
    logic [NumRegs-1:0] busy;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, claim_valid, claim_addr,
        input  a_ready, b_ready, rf_write_enable, rf_addr_write, rf_in, busy
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, claim_valid, claim_addr,
        output a_ready, b_ready, rf_write_enable, rf_addr_write, rf_in, busy
    );
`else
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_write_enable, rf_addr_write, rf_in
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_write_enable, rf_addr_write, rf_in
    );
`endif

endinterface

// File: rtl/regfile_write_arbiter_write_fifo.sv
// In-order buffer of pending long-latency writes; entries matching a squash address are
// dropped and the survivors compacted toward the head in the same cycle.
module write_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  BufEntry   push_entry_i,
    input  logic      pop_i,
    input  logic      squash_i,
    input  RegAddress squash_addr_i,
    output BufEntry   head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned IdxW = $clog2(Depth);

    BufEntry          ent_q [Depth];
    BufEntry          ent_d [Depth];
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Depth-1:0] keep;

    assign head_o  = ent_q[0];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));

    always_comb begin
        keep = '0;
        for (int i = 0; i < Depth; i++) begin
            keep[i] = (CntW'(i) < cnt_q) && !(pop_i && (i == 0)) &&
                      !(squash_i && (ent_q[i].addr == squash_addr_i));
        end
    end

    // Survivors slide down in order; a new entry lands just behind them.
    always_comb begin
        ent_d = ent_q;
        cnt_d = '0;
        for (int i = 0; i < Depth; i++) begin
            if (keep[i]) begin
                ent_d[cnt_d[IdxW-1:0]] = ent_q[i];
                cnt_d = cnt_d + CntW'(1);
            end
        end
        if (push_i && !full_o) begin
            ent_d[cnt_d[IdxW-1:0]] = push_entry_i;
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-port register-file write arbiter: pipeline writes (A) pass through combinationally,
// long-latency writes (B) are buffered. Build option: REGFILE_SCOREBOARD_EN adds busy flags.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BUF_DEPTH    = 2
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);

    logic [3:0] starve_q, starve_d;
    BufEntry    head, b_entry;
    logic       empty, full;
    logic       force_b, a_grant, b_write;

    assign b_entry = '{addr: bus.b_addr, data: bus.b_data};

    write_fifo #(
        .Depth (BUF_DEPTH)
    ) u_write_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (bus.b_valid),
        .push_entry_i (b_entry),
        .pop_i        (b_write),
        .squash_i     (a_grant),
        .squash_addr_i(bus.a_addr),
        .head_o       (head),
        .empty_o      (empty),
        .full_o       (full)
    );

    // Reset gating keeps the handshake outputs defined before state has ever been cleared.
    always_comb begin
        force_b             = !reset && !empty && (starve_q == 4'(STARVE_LIMIT));
        bus.a_ready         = !force_b;
        bus.b_ready         = reset || !full;
        a_grant             = !reset && bus.a_valid && !force_b;
        b_write             = !reset && !empty && !a_grant;
        bus.rf_write_enable = 1'b0;
        bus.rf_addr_write   = '0;
        bus.rf_in           = '0;
        if (a_grant) begin
            bus.rf_write_enable = (bus.a_addr != '0);
            bus.rf_addr_write   = bus.a_addr;
            bus.rf_in           = bus.a_data;
        end else if (b_write) begin
            bus.rf_write_enable = (head.addr != '0);
            bus.rf_addr_write   = head.addr;
            bus.rf_in           = head.data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (b_write || empty) begin
            starve_d = '0;
        end else if (a_grant && (starve_q != 4'(STARVE_LIMIT))) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NumRegs-1:0] busy_q, busy_d;

    assign bus.busy = busy_q;

    // Claim is applied after the clear so a same-cycle claim of the drained register wins.
    always_comb begin
        busy_d = busy_q;
        if (b_write) busy_d[head.addr] = 1'b0;
        if (bus.claim_valid) busy_d[bus.claim_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int unsigned StarveLimit = 4;
    localparam int unsigned BufDepth    = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    Word  rf_img [NumRegs];

    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .STARVE_LIMIT(StarveLimit),
        .BUF_DEPTH   (BufDepth)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Register-file image built from the observed write port.
    always @(negedge clk) begin
        if (bus.rf_write_enable === 1'b1) rf_img[bus.rf_addr_write] = bus.rf_in;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
        bus.claim_valid = 1'b0; bus.claim_addr = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        bus.a_valid = 1'b1; bus.a_addr = 5; bus.b_valid = 1'b1; bus.b_addr = 6;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++;
            $display("FAIL reset_a_ready: got %b want 1", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b1) begin errors++;
            $display("FAIL reset_b_ready: got %b want 1", bus.b_ready); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL reset_we: got %b want 0", bus.rf_write_enable); end
        tick();
        reset = 1'b0; idle();
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL post_reset_we: got %b want 0", bus.rf_write_enable); end
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_ready: got %b%b want 11", bus.a_ready, bus.b_ready); end
        checks++; if (bus.rf_addr_write !== 5'd0 || bus.rf_in !== 32'd0) begin errors++;
            $display("FAIL idle_outputs: got %0d/%0d want 0/0", bus.rf_addr_write, bus.rf_in);
        end
        tick();
    endtask

    task automatic test_a_only();
        idle(); bus.a_valid = 1'b1; bus.a_addr = 5; bus.a_data = 51;
        #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_write !== 5'd5 ||
                      bus.rf_in !== 32'd51) begin errors++;
            $display("FAIL a_only: got we=%b addr=%0d data=%0d want 1/5/51",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick(); idle();
    endtask

    task automatic test_b_only();
        idle(); bus.b_valid = 1'b1; bus.b_addr = 7; bus.b_data = 70;
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.b_ready !== 1'b1) begin errors++;
            $display("FAIL b_enqueue_cycle: got we=%b b_ready=%b want 0/1",
                     bus.rf_write_enable, bus.b_ready); end
        tick(); idle(); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_write !== 5'd7 ||
                      bus.rf_in !== 32'd70) begin errors++;
            $display("FAIL b_only: got we=%b addr=%0d data=%0d want 1/7/70",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick(); #1;
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.rf_addr_write !== 5'd0 ||
                      bus.rf_in !== 32'd0) begin errors++;
            $display("FAIL b_after_idle: got we=%b addr=%0d data=%0d want 0/0/0",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick();
    endtask

    task automatic test_starvation();
        idle(); bus.b_valid = 1'b1; bus.b_addr = 9; bus.b_data = 90;
        tick(); idle();
        for (int k = 0; k < StarveLimit; k++) begin
            bus.a_valid = 1'b1; bus.a_addr = 5'(10 + k); bus.a_data = 32'(100 + k);
            #1;
            checks++; if (bus.a_ready !== 1'b1 || bus.rf_addr_write !== 5'(10 + k)) begin
                errors++;
                $display("FAIL starve_a_win%0d: got ready=%b addr=%0d want 1/%0d",
                         k, bus.a_ready, bus.rf_addr_write, 10 + k); end
            tick();
        end
        bus.a_addr = 14; bus.a_data = 140;
        #1;
        checks++; if (bus.a_ready !== 1'b0 || bus.rf_write_enable !== 1'b1 ||
                      bus.rf_addr_write !== 5'd9 || bus.rf_in !== 32'd90) begin errors++;
            $display("FAIL starve_forced_b: got ready=%b we=%b addr=%0d data=%0d want 0/1/9/90",
                     bus.a_ready, bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick(); #1;
        checks++; if (bus.a_ready !== 1'b1 || bus.rf_addr_write !== 5'd14) begin errors++;
            $display("FAIL starve_release: got ready=%b addr=%0d want 1/14",
                     bus.a_ready, bus.rf_addr_write); end
        tick(); idle(); tick();
    endtask

    task automatic test_full();
        idle();
        for (int c = 0; c < 6; c++) begin
            bus.a_valid = 1'b1; bus.a_addr = 5'(20 + c); bus.b_valid = 1'b1;
            bus.b_addr = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd3;
            bus.b_data = (c == 0) ? 32'd11 : (c == 1) ? 32'd22 : 32'd33;
            #1;
            checks++; if (bus.b_ready !== (c < 2)) begin errors++;
                $display("FAIL full_b_ready_c%0d: got %b want %b", c, bus.b_ready, c < 2); end
            if (c == 5) begin
                checks++; if (bus.a_ready !== 1'b0 || bus.rf_addr_write !== 5'd1 ||
                              bus.rf_in !== 32'd11) begin errors++;
                    $display("FAIL full_drain_head: got ready=%b addr=%0d data=%0d want 0/1/11",
                             bus.a_ready, bus.rf_addr_write, bus.rf_in); end
            end
            tick();
        end
        bus.a_addr = 26;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b1) begin errors++;
            $display("FAIL full_space_freed: got b=%b a=%b want 1/1", bus.b_ready, bus.a_ready);
        end
        tick(); idle(); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_write !== 5'd2 ||
                      bus.rf_in !== 32'd22) begin errors++;
            $display("FAIL full_second: got we=%b addr=%0d data=%0d want 1/2/22",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick(); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_write !== 5'd3 ||
                      bus.rf_in !== 32'd33) begin errors++;
            $display("FAIL full_third_held: got we=%b addr=%0d data=%0d want 1/3/33",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick(); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL full_empty_after: got we=%b want 0", bus.rf_write_enable); end
        tick();
    endtask

    task automatic test_waw();
        idle(); bus.a_valid = 1'b1; bus.a_addr = 20; bus.a_data = 200;
        bus.b_valid = 1'b1; bus.b_addr = 3; bus.b_data = 30;
        tick(); idle();
        bus.a_valid = 1'b1; bus.a_addr = 3; bus.a_data = 33;
        #1;
        checks++; if (bus.rf_addr_write !== 5'd3 || bus.rf_in !== 32'd33) begin errors++;
            $display("FAIL waw_a_write: got addr=%0d data=%0d want 3/33",
                     bus.rf_addr_write, bus.rf_in); end
        tick(); idle(); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL waw_squashed: got we=%b want 0", bus.rf_write_enable); end
        tick(); tick();
        checks++; if (rf_img[3] !== 32'd33) begin errors++;
            $display("FAIL waw_final_r3: got %0d want 33", rf_img[3]); end
    endtask

    task automatic test_zero_reg();
        idle(); bus.a_valid = 1'b1; bus.a_addr = 0; bus.a_data = 5;
        #1;
        checks++; if (bus.a_ready !== 1'b1 || bus.rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL r0_a: got ready=%b we=%b want 1/0", bus.a_ready, bus.rf_write_enable);
        end
        tick(); idle(); bus.b_valid = 1'b1; bus.b_addr = 0; bus.b_data = 9;
        tick(); bus.b_addr = 4; bus.b_data = 44;
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.b_ready !== 1'b1) begin errors++;
            $display("FAIL r0_b_drain: got we=%b b_ready=%b want 0/1",
                     bus.rf_write_enable, bus.b_ready); end
        tick(); idle(); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_write !== 5'd4 ||
                      bus.rf_in !== 32'd44) begin errors++;
            $display("FAIL r0_b_next: got we=%b addr=%0d data=%0d want 1/4/44",
                     bus.rf_write_enable, bus.rf_addr_write, bus.rf_in); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle(); bus.a_valid = 1'b1; bus.a_addr = 21; bus.b_valid = 1'b1;
        bus.b_addr = 6; bus.b_data = 60;
        tick(); bus.a_addr = 22; bus.b_addr = 8; bus.b_data = 80;
        tick(); reset = 1'b1; idle();
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.a_ready !== 1'b1 ||
                      bus.b_ready !== 1'b1) begin errors++;
            $display("FAIL reset_mid_during: got we=%b a=%b b=%b want 0/1/1",
                     bus.rf_write_enable, bus.a_ready, bus.b_ready); end
        tick(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.rf_write_enable !== 1'b0 || bus.b_ready !== 1'b1) begin errors++;
                $display("FAIL reset_mid_after%0d: got we=%b b_ready=%b want 0/1",
                         k, bus.rf_write_enable, bus.b_ready); end
            tick();
        end
    endtask

`ifdef REGFILE_SCOREBOARD_EN
    task automatic test_scoreboard();
        idle(); bus.claim_valid = 1'b1; bus.claim_addr = 12;
        #1;
        checks++; if (bus.busy[12] !== 1'b0) begin errors++;
            $display("FAIL sb_before_claim: got %b want 0", bus.busy[12]); end
        tick(); idle(); bus.b_valid = 1'b1; bus.b_addr = 12; bus.b_data = 120;
        #1;
        checks++; if (bus.busy[12] !== 1'b1) begin errors++;
            $display("FAIL sb_claimed: got %b want 1", bus.busy[12]); end
        tick(); idle(); #1;
        checks++; if (bus.rf_addr_write !== 5'd12 || bus.busy[12] !== 1'b1) begin errors++;
            $display("FAIL sb_writing: got addr=%0d busy=%b want 12/1",
                     bus.rf_addr_write, bus.busy[12]); end
        tick(); #1;
        checks++; if (bus.busy[12] !== 1'b0) begin errors++;
            $display("FAIL sb_cleared: got %b want 0", bus.busy[12]); end
        bus.b_valid = 1'b1; bus.b_addr = 12; bus.b_data = 121;
        tick(); idle(); bus.claim_valid = 1'b1; bus.claim_addr = 12;
        tick(); idle(); bus.claim_valid = 1'b1; bus.claim_addr = 0;
        #1;
        checks++; if (bus.busy[12] !== 1'b1) begin errors++;
            $display("FAIL sb_claim_wins: got %b want 1", bus.busy[12]); end
        tick(); bus.claim_addr = 13;
        #1;
        checks++; if (bus.busy[0] !== 1'b0) begin errors++;
            $display("FAIL sb_r0: got %b want 0", bus.busy[0]); end
        tick(); idle(); reset = 1'b1;
        #1;
        checks++; if (bus.busy[13] !== 1'b1) begin errors++;
            $display("FAIL sb_r13: got %b want 1", bus.busy[13]); end
        tick(); reset = 1'b0; #1;
        checks++; if (bus.busy !== '0) begin errors++;
            $display("FAIL sb_reset: got %h want 0", bus.busy); end
        tick();
    endtask
`endif

    task automatic test_random();
        BufEntry            q[$];
        int                 starve;
        bit                 busy_m [NumRegs];
        logic [NumRegs-1:0] exp_busy;
        bit                 rst, force_b, ga, bw, acc, exp_we;
        RegAddress          exp_addr;
        Word                exp_data;
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        starve = 0;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        repeat (600) begin
            rst = ($urandom_range(0, 63) == 0);
            reset = rst;
            bus.a_valid = 1'($urandom_range(0, 1)); bus.a_addr = 5'($urandom_range(0, 7));
            bus.a_data = $urandom;
            bus.b_valid = 1'($urandom_range(0, 1)); bus.b_addr = 5'($urandom_range(0, 7));
            bus.b_data = $urandom;
`ifdef REGFILE_SCOREBOARD_EN
            bus.claim_valid = 1'($urandom_range(0, 1));
            bus.claim_addr = 5'($urandom_range(0, 7));
`endif
            #1;
            force_b = !rst && (starve == StarveLimit) && (q.size() > 0);
            ga = !rst && bus.a_valid && !force_b;
            bw = !rst && !ga && (q.size() > 0);
            exp_addr = ga ? bus.a_addr : bw ? q[0].addr : '0;
            exp_data = ga ? bus.a_data : bw ? q[0].data : '0;
            exp_we = (ga || bw) && (exp_addr != 0);
            checks++; if (bus.a_ready !== !force_b) begin errors++;
                $display("FAIL rnd_a_ready: got %b want %b", bus.a_ready, !force_b); end
            checks++; if (bus.b_ready !== (rst || q.size() < BufDepth)) begin errors++;
                $display("FAIL rnd_b_ready: got %b want %b", bus.b_ready,
                         rst || q.size() < BufDepth); end
            checks++; if (bus.rf_write_enable !== exp_we) begin errors++;
                $display("FAIL rnd_we: got %b want %b", bus.rf_write_enable, exp_we); end
            if (exp_we || (!rst && !ga && !bw)) begin
                checks++; if (bus.rf_addr_write !== exp_addr || bus.rf_in !== exp_data) begin
                    errors++;
                    $display("FAIL rnd_write: got %0d/%h want %0d/%h",
                             bus.rf_addr_write, bus.rf_in, exp_addr, exp_data); end
            end
`ifdef REGFILE_SCOREBOARD_EN
            foreach (busy_m[i]) exp_busy[i] = busy_m[i];
            checks++; if (bus.busy !== exp_busy) begin errors++;
                $display("FAIL rnd_busy: got %h want %h", bus.busy, exp_busy); end
`else
            exp_busy = '0;
`endif
            tick();
            if (rst) begin
                q.delete(); starve = 0;
                foreach (busy_m[i]) busy_m[i] = 1'b0;
            end else begin
                acc = bus.b_valid && (q.size() < BufDepth);
                if (bw) begin
                    busy_m[q[0].addr] = 1'b0;
                    void'(q.pop_front());
                    starve = 0;
                end else if (q.size() == 0) begin
                    starve = 0;
                end else if (ga && starve < StarveLimit) begin
                    starve++;
                end
                if (ga) begin
                    for (int i = q.size() - 1; i >= 0; i--) begin
                        if (q[i].addr == bus.a_addr) q.delete(i);
                    end
                end
                if (acc) q.push_back('{addr: bus.b_addr, data: bus.b_data});
`ifdef REGFILE_SCOREBOARD_EN
                if (bus.claim_valid) busy_m[bus.claim_addr] = 1'b1;
`endif
                busy_m[0] = 1'b0;
            end
        end
        reset = 1'b0; idle(); tick();
    endtask

    initial begin
        foreach (rf_img[i]) rf_img[i] = '0;
        test_reset();
        test_a_only();
        test_b_only();
        test_starvation();
        test_full();
        test_waw();
        test_zero_reg();
        test_reset_mid();
`ifdef REGFILE_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
